// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        REQ       = 3'd0,
        WAIT_RESP = 3'd1,
        DONE      = 3'd2,
        WAIT_NEXT = 3'd3,
        FAULT     = 3'd4
    } ifu_state_e;

    // Fault cause encoding reported on fault_cause.
    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUSERR   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    // addi x0, x0, 0: harmless instruction shown before the first fetch.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Boot address of the core.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    // Default response budget in WAIT_RESP.
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    // Instructions are 32-bit words; the two low address bits must be zero.
    function automatic logic pc_is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifu_timeout_ctr.sv
// Response timeout counter: counts waiting cycles and flags the last
// allowed one. With count starting at 0 on the first waiting cycle, the
// LIMIT-th waiting cycle is the one where count == LIMIT-1, so terminal
// marks the cycle in which a missing response becomes a timeout.
module ifu_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] count;

    // Count enabled cycles; clear has priority; saturate instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 16'd0;
        end else if (clear) begin
            count <= 16'd0;
        end else if (enable && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

    // Terminal flag for the current cycle.
    always_comb begin
        terminal = (count == LAST);
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, fetches one word at a time over a
// valid/ready memory port, hands it to decode with a one-cycle IFU_done
// pulse, then waits for writeback to supply the next PC. Misaligned PCs,
// bus errors and response timeouts park the unit in a sticky FAULT state.
//
// Handshake: a request transfers on a rising edge where imem_req_valid and
// imem_req_ready are both 1; while valid is high without ready, imem_addr is
// held unchanged and valid is not withdrawn. Responses carry no ready: a
// response is taken on any edge with imem_resp_valid=1 while in WAIT_RESP,
// imem_resp_err qualifies it, and it is ignored in every other state.
module ifu_fetch import ifu_pkg::*; #(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        next_pc_valid,
    input  logic [31:0] next_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp_err,
    output logic        IFU_done,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause,
    output logic        busy
);

    // Sequencer state; kept as a named enum so it is visible for debug.
    ifu_state_e  state;
    ifu_state_e  state_next;

    logic [31:0] pc_q;
    logic [31:0] insn_q;
    logic [1:0]  cause_q;
    logic [1:0]  cause_next;
    logic        req_valid_q;

    logic        req_fire;
    logic        resp_take;
    logic        ctr_clear;
    logic        ctr_enable;
    logic        ctr_terminal;
    logic        pc_load;
    logic        insn_load;

    ifu_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst      (rst),
        .clear    (ctr_clear),
        .enable   (ctr_enable),
        .terminal (ctr_terminal)
    );

    // Next-state, fault-cause and datapath-enable decode.
    always_comb begin
        state_next = state;
        cause_next = cause_q;
        ctr_clear  = 1'b0;
        ctr_enable = 1'b0;
        pc_load    = 1'b0;
        insn_load  = 1'b0;
        req_fire   = req_valid_q && imem_req_ready;
        resp_take  = 1'b0;

        case (state)
            REQ: begin
                // req_valid_q is low only in the first cycle after reset.
                if (req_fire) begin
                    state_next = WAIT_RESP;
                    ctr_clear  = 1'b1;
                end
            end
            WAIT_RESP: begin
                // A response in the terminal cycle still wins over timeout.
                if (imem_resp_valid) begin
                    resp_take = 1'b1;
                    if (imem_resp_err) begin
                        state_next = FAULT;
                        cause_next = CAUSE_BUSERR;
                    end else begin
                        state_next = DONE;
                        insn_load  = 1'b1;
                    end
                end else if (ctr_terminal) begin
                    state_next = FAULT;
                    cause_next = CAUSE_TIMEOUT;
                end else begin
                    ctr_enable = 1'b1;
                end
            end
            DONE: begin
                state_next = WAIT_NEXT;
            end
            WAIT_NEXT: begin
                // The PC is taken even when misaligned, for diagnostics.
                if (next_pc_valid) begin
                    pc_load = 1'b1;
                    if (pc_is_aligned(next_pc)) begin
                        state_next = REQ;
                    end else begin
                        state_next = FAULT;
                        cause_next = CAUSE_MISALIGN;
                    end
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = FAULT;
            end
        endcase
    end

    // State register; reset returns to REQ and drops any in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    // Registered request valid: high for every cycle spent in REQ except
    // the first cycle after reset, so it never rises during reset itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid_q <= 1'b0;
        end else begin
            req_valid_q <= (state_next == REQ);
        end
    end

    // Architectural PC, updated only from writeback in WAIT_NEXT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (pc_load) begin
            pc_q <= next_pc;
        end
    end

    // Last good instruction word; errored responses leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            insn_q <= NOP_INSN;
        end else if (insn_load) begin
            insn_q <= imem_rdata;
        end
    end

    // Sticky fault cause, written once on the transition into FAULT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_q <= CAUSE_NONE;
        end else if (state != FAULT) begin
            cause_q <= cause_next;
        end
    end

    // Output mapping.
    always_comb begin
        imem_req_valid = req_valid_q;
        imem_addr      = pc_q;
        IFU_done       = (state == DONE);
        instruction    = insn_q;
        pc             = pc_q;
        fetch_fault    = (state == FAULT);
        fault_cause    = cause_q;
        busy           = (state == REQ) || (state == WAIT_RESP);
    end

endmodule
